uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, pointer width; DEPTH == 2**AW.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  in  1  bus push strobe, one byte per high cycle.
REQ-006 SHALL have port wr_data  in  8  byte to push.
REQ-007 SHALL have port ovf_clr  in  1  clears overflow flag.
REQ-008 SHALL have port tx_active  in  1  serializer busy flag from the UART transmitter.
REQ-009 SHALL have port tx_done  in  1  one-cycle end-of-byte pulse from the UART transmitter.
REQ-010 SHALL have port tx_dv  out  1  one-cycle start strobe to the transmitter.
REQ-011 SHALL have port tx_byte  out  8  byte presented to the transmitter; stable from tx_dv until tx_done.
REQ-012 SHALL have port full  out  1  count == DEPTH.
REQ-013 SHALL have port empty  out  1  count == 0.
REQ-014 SHALL have port count  out  AW+1  bytes stored, 0..DEPTH.
REQ-015 SHALL have port overflow  out  1  sticky; a push was dropped.
REQ-016 SHALL have port busy  out  1  state != IDLE or !empty.

Function
REQ-017 SHALL store bytes in circular order; rd_ptr/wr_ptr AW bits, wrap DEPTH-1 -> 0 silently.
REQ-018 SHALL accept a push when wr_en && !full at the start of the cycle; count +1 at that edge.
REQ-019 SHALL drop wr_en while full, leave storage and pointers unchanged, and set overflow next edge.
REQ-020 SHALL clear overflow on ovf_clr; ovf_clr and a dropped push in the same cycle leave overflow set.
REQ-021 SHALL use FSM states IDLE, LOAD, WAIT_ACT, WAIT_DONE, GAP.
REQ-022 IDLE -> LOAD when !empty; at that edge SHALL register tx_byte = mem[rd_ptr], advance rd_ptr, and decrement count.
REQ-023 LOAD SHALL assert tx_dv for exactly one cycle, then go to WAIT_ACT.
REQ-024 WAIT_ACT -> WAIT_DONE when tx_active == 1; after 4 cycles without tx_active SHALL return to LOAD and re-strobe the same byte.
REQ-025 WAIT_DONE -> GAP on tx_done; GAP SHALL last one cycle, then IDLE.
REQ-026 Minimum push-to-tx_dv latency SHALL be 2 edges: push at edge N, IDLE->LOAD at N+1, tx_dv high during cycle N+1..N+2.
REQ-027 Simultaneous push and pop in one cycle SHALL leave count unchanged, and SHALL be legal when full.
REQ-028 A push into an empty FIFO while in IDLE SHALL become visible to the FSM at the following edge only.
REQ-029 tx_done outside WAIT_DONE SHALL be ignored.
REQ-030 full, empty, and busy SHALL be combinational from registered count and state.

Reset
REQ-031 On reset low, asynchronously: state = IDLE, pointers = 0, count = 0, tx_dv = 0, tx_byte = 0, overflow = 0.
REQ-032 Reset outputs SHALL be: full = 0, empty = 1, busy = 0.
REQ-033 Reset mid-transfer SHALL abandon the byte in flight; storage contents need not be cleared.
REQ-034 On the first edge after reset release, wr_en SHALL be honoured normally.

Structure
REQ-035 A shared package uart_pkg SHALL hold the FSM state encoding and the WAIT_ACT timeout constant (4).
REQ-036 Storage SHALL be one sub-module uart_fifo_mem: DEPTH x 8 register array, synchronous write, asynchronous read.
REQ-037 Pointer, count, overflow, and FSM logic SHALL remain in uart_tx_fifo.

Verification
REQ-038 Single byte: push 0x41 into empty FIFO -> tx_dv one cycle 2 edges later with tx_byte = 0x41; with model tx_active/tx_done, busy drops 1 cycle after GAP.
REQ-039 Burst: push 0x00..0x0F back-to-back (DEPTH 16) -> full after 16th push; serial order 0x00..0x0F; count returns to 0; overflow stays 0.
REQ-040 Overflow: fill 16, push 0xAA while FSM held in WAIT_DONE -> overflow = 1, 0xAA never transmitted; ovf_clr -> overflow = 0.
REQ-041 Wrap: push/drain 20 bytes 0x10..0x23 -> pointers wrap, order preserved, no byte lost.
REQ-042 Timeout: hold tx_active low after tx_dv -> tx_dv re-asserted 5 cycles later with the same tx_byte.
REQ-043 Reset mid-transfer: reset low during WAIT_DONE with count = 3 -> all outputs at reset values; next push 0x55 transmitted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: FSM state encoding and the
// handshake timeout used while waiting for the transmitter to go active.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_ACT  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } tx_state_e;

    // Cycles spent in WAIT_ACT without tx_active before the byte is re-strobed.
    localparam int ACT_TIMEOUT = 4;
    localparam int TMR_W       = $clog2(ACT_TIMEOUT);

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the transmit FIFO: DEPTH x 8 register array,
// synchronous write port and asynchronous read port.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    // NOTE: the array has no reset; pointers and count define which entries are
    // valid, so stale contents are never observed and the array stays plain flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: pointer/count/overflow bookkeeping
// plus a handshake FSM that strobes each byte out and waits for completion.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        ovf_clr,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        overflow,
    output logic        busy
);

    localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACT_TIMEOUT - 1);

    tx_state_e        state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       rd_data;
    logic             push_ok, pop, drop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a push while full is still taken.
    assign pop     = (state_q == IDLE) && !empty;
    assign push_ok = wr_en && (!full || pop);
    assign drop    = wr_en && !push_ok;

    uart_fifo_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (push_ok),
        .waddr(wr_ptr_q),
        .wdata(wr_data),
        .raddr(rd_ptr_q),
        .rdata(rd_data)
    );

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        tx_byte_d = tx_byte_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_byte_d = rd_data;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) state_d = LOAD;
            end
            LOAD: begin
                state_d = WAIT_ACT;
                tmr_d   = '0;
            end
            WAIT_ACT: begin
                if (tx_active) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = LOAD;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_done) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_dv = (state_q == LOAD);
        busy  = (state_q != IDLE) || !empty;
    end

    assign tx_byte  = tx_byte_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;

    localparam int DEPTH     = 16;
    localparam int AW        = 4;
    localparam int ACT_LIMIT = 4;

    typedef enum int {R_AUTO, R_HOLD, R_MUTE} resp_mode_e;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          ovf_clr;
    logic          tx_active;
    logic          tx_done;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          busy;

    int            n_checks = 0;
    int            n_errors = 0;
    resp_mode_e    mode = R_AUTO;
    logic [7:0]    sent_q[$];

    // Reference model: byte queue plus a description of where the link is.
    logic [7:0]    mq[$];
    logic          m_strobe  = 1'b0;
    int            m_age     = -1;
    logic          m_sending = 1'b0;
    logic          m_gap     = 1'b0;
    logic          m_ovf     = 1'b0;
    logic [7:0]    m_byte    = 8'h00;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .tx_active(tx_active),
        .tx_done  (tx_done),
        .tx_dv    (tx_dv),
        .tx_byte  (tx_byte),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic m_link_idle();
        return !m_strobe && (m_age < 0) && !m_sending && !m_gap;
    endfunction

    // Model advance at each clock edge; asynchronous reset clears it.
    initial begin
        logic pop_now;
        logic push_now;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mq.delete();
                m_strobe  = 1'b0;
                m_age     = -1;
                m_sending = 1'b0;
                m_gap     = 1'b0;
                m_ovf     = 1'b0;
                m_byte    = 8'h00;
            end else begin
                pop_now  = m_link_idle() && (mq.size() > 0);
                push_now = wr_en && ((mq.size() < DEPTH) || pop_now);
                if (wr_en && !push_now) m_ovf = 1'b1;
                else if (ovf_clr)       m_ovf = 1'b0;
                if (pop_now) begin
                    m_byte   = mq.pop_front();
                    m_strobe = 1'b1;
                end else if (m_strobe) begin
                    m_strobe = 1'b0;
                    m_age    = 0;
                end else if (m_age >= 0) begin
                    if (tx_active) begin
                        m_age     = -1;
                        m_sending = 1'b1;
                    end else if (m_age == ACT_LIMIT - 1) begin
                        m_age    = -1;
                        m_strobe = 1'b1;
                    end else begin
                        m_age++;
                    end
                end else if (m_sending) begin
                    if (tx_done) begin
                        m_sending = 1'b0;
                        m_gap     = 1'b1;
                    end
                end else if (m_gap) begin
                    m_gap = 1'b0;
                end
                if (push_now) mq.push_back(wr_data);
            end
        end
    end

    // Compare DUT against the model on every falling edge; log strobed bytes.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_tx_dv",    tx_dv,    m_strobe);
            check("cmp_tx_byte",  tx_byte,  m_byte);
            check("cmp_count",    count,    mq.size());
            check("cmp_full",     full,     mq.size() == DEPTH);
            check("cmp_empty",    empty,    mq.size() == 0);
            check("cmp_overflow", overflow, m_ovf);
            check("cmp_busy",     busy,     !m_link_idle() || (mq.size() > 0));
            if (tx_dv) sent_q.push_back(tx_byte);
        end
    end

    // Transmitter stand-in: AUTO goes active after a strobe and ends with tx_done
    // three cycles later; HOLD stays active forever; MUTE never responds.
    initial begin
        int   left;
        logic dv_s;
        left      = 0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            dv_s = tx_dv;
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!reset) begin
                tx_active = 1'b0;
                left      = 0;
            end else begin
                if (left > 0 && mode == R_AUTO) begin
                    left--;
                    if (left == 0) begin
                        tx_active = 1'b0;
                        tx_done   = 1'b1;
                    end
                end
                if (dv_s && mode != R_MUTE) begin
                    tx_active = 1'b1;
                    left      = 3;
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || tx_active) && n < 300) begin
            step();
            n++;
        end
        check({tag, "_idle_bound"}, n < 300, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_full"},     full,     1'b0);
        check({tag, "_empty"},    empty,    1'b1);
        check({tag, "_busy"},     busy,     1'b0);
        check({tag, "_count"},    count,    0);
        check({tag, "_tx_dv"},    tx_dv,    1'b0);
        check({tag, "_tx_byte"},  tx_byte,  8'h00);
        check({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int mark;
        int n77;
        logic bad_seen;

        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        repeat (3) step();
        check_reset_values("por");

        // Single byte; push on the very first edge after reset release.
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h41;
        step();
        wr_en = 1'b0;
        check("single_count_after_push", count, 1);
        check("single_no_dv_yet", tx_dv, 1'b0);
        check("single_busy", busy, 1'b1);
        step();
        check("single_dv", tx_dv, 1'b1);
        check("single_byte", tx_byte, 8'h41);
        check("single_count_after_pop", count, 0);
        repeat (5) step();
        check("single_gap_busy", busy, 1'b1);
        check("single_gap_dv", tx_dv, 1'b0);
        step();
        check("single_idle_busy", busy, 1'b0);
        check("single_byte_held", tx_byte, 8'h41);

        // Burst of 16 while a leader byte holds the FSM in WAIT_DONE.
        mode    = R_HOLD;
        mark    = sent_q.size();
        wr_en   = 1'b1;
        wr_data = 8'hC3;
        step();
        wr_en = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("burst_count16", count, 16);
        check("burst_full", full, 1'b1);
        check("burst_ovf", overflow, 1'b0);
        mode = R_AUTO;
        wait_idle("burst");
        check("burst_sent_n", sent_q.size() - mark, 17);
        check("burst_leader", sent_q[mark], 8'hC3);
        for (int i = 0; i < 16; i++) check($sformatf("burst_order_%0d", i), sent_q[mark + 1 + i], 8'(i));
        check("burst_count_end", count, 0);
        check("burst_ovf_end", overflow, 1'b0);

        // Overflow: fill while held, drop 0xAA, then clear rules.
        mode    = R_HOLD;
        mark    = sent_q.size();
        wr_en   = 1'b1;
        wr_data = 8'hE1;
        step();
        wr_en = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h80 + 8'(i);
            step();
        end
        wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        check("ovf_set", overflow, 1'b1);
        check("ovf_count", count, 16);
        ovf_clr = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hAB;
        step();
        wr_en = 1'b0;
        check("ovf_clr_vs_drop", overflow, 1'b1);
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        // Release the transmitter while pushing: only the push that lands on
        // the pop edge fits.
        mode    = R_AUTO;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        repeat (8) step();
        wr_en   = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        wait_idle("ovf");
        check("ovf_sent_n", sent_q.size() - mark, 18);
        check("ovf_leader", sent_q[mark], 8'hE1);
        for (int i = 0; i < 16; i++) check($sformatf("ovf_order_%0d", i), sent_q[mark + 1 + i], 8'h80 + 8'(i));
        bad_seen = 1'b0;
        n77      = 0;
        for (int i = mark; i < sent_q.size(); i++) begin
            if (sent_q[i] == 8'hAA || sent_q[i] == 8'hAB) bad_seen = 1'b1;
            if (sent_q[i] == 8'h77) n77++;
        end
        check("ovf_dropped_never_sent", bad_seen, 1'b0);
        check("ovf_push_on_pop_taken", n77, 1);
        check("ovf_final", overflow, 1'b0);

        // Wrap: 20 bytes trickled in, drained in order.
        mark = sent_q.size();
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h10 + 8'(i);
            step();
            wr_en = 1'b0;
            repeat (3) step();
        end
        wait_idle("wrap");
        check("wrap_sent_n", sent_q.size() - mark, 20);
        for (int i = 0; i < 20; i++) check($sformatf("wrap_order_%0d", i), sent_q[mark + i], 8'h10 + 8'(i));
        check("wrap_empty", empty, 1'b1);

        // Timeout: silent transmitter gets the same byte re-strobed 5 cycles on.
        mode    = R_MUTE;
        mark    = sent_q.size();
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        step();
        check("to_first_dv", tx_dv, 1'b1);
        check("to_first_byte", tx_byte, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("to_quiet_%0d", i), tx_dv, 1'b0);
        end
        step();
        check("to_redv", tx_dv, 1'b1);
        check("to_rebyte", tx_byte, 8'h5A);
        check("to_count", count, 0);
        mode = R_AUTO;
        wait_idle("to");
        check("to_sent_n", sent_q.size() - mark, 2);

        // Reset in WAIT_DONE with three bytes queued.
        mode    = R_HOLD;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h31 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("rst_pre_count", count, 3);
        check("rst_pre_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        step();
        mode    = R_AUTO;
        mark    = sent_q.size();
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        step();
        check("postrst_dv", tx_dv, 1'b1);
        check("postrst_byte", tx_byte, 8'h55);
        wait_idle("postrst");
        check("postrst_sent_n", sent_q.size() - mark, 1);
        check("postrst_first", sent_q[mark], 8'h55);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
